seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS hex seven-segment digits with a shared segment bus.

---
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_driver
// Brief  : Time-multiplexed hex seven-segment scanner with dead time,
//          digit enables, leading-zero blanking and frame-aligned double buffer.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int C_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [C_CNT_W-1:0]    C_CNT_MAX   = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [C_CNT_W-1:0]    C_DEAD_LAST = C_CNT_W'(DEAD_CYCLES - 1);
  localparam logic [C_IDX_W-1:0]    C_IDX_MAX   = C_IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF    = {NUM_DIGITS{ACTIVE_LOW_AN}};
  localparam logic [6:0]            C_SEG_OFF   = {7{ACTIVE_LOW_SEG}};
  localparam logic                  C_DP_OFF    = ACTIVE_LOW_SEG;

  typedef enum logic [0:0] {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [C_CNT_W-1:0]      w_cnt_nxt;
  logic [C_IDX_W-1:0]      r_idx;
  logic [C_IDX_W-1:0]      w_idx_nxt;
  logic                    w_cnt_wrap;
  logic                    w_frame;

  logic [4*NUM_DIGITS-1:0] r_shd_data;
  logic [NUM_DIGITS-1:0]   r_shd_dp;
  logic [NUM_DIGITS-1:0]   r_shd_en;
  logic                    r_shd_blz;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic                    r_act_blz;

  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic                    w_run;
  logic [3:0]              w_nib;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_an_raw;
  logic [6:0]              w_seg_raw;
  logic                    w_dp_raw;

  // Active-low {a..g} patterns.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h01;  4'h1: pat = 7'h4F;  4'h2: pat = 7'h12;  4'h3: pat = 7'h06;
      4'h4: pat = 7'h4C;  4'h5: pat = 7'h24;  4'h6: pat = 7'h20;  4'h7: pat = 7'h0F;
      4'h8: pat = 7'h00;  4'h9: pat = 7'h0C;  4'hA: pat = 7'h08;  4'hB: pat = 7'h60;
      4'hC: pat = 7'h31;  4'hD: pat = 7'h42;  4'hE: pat = 7'h30;  default: pat = 7'h38;
    endcase
    return pat;
  endfunction

  always_comb begin
    w_cnt_wrap = (r_cnt == C_CNT_MAX);
    w_frame    = w_cnt_wrap && (r_idx == C_IDX_MAX);
    w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt  = r_idx;
    if (w_frame) begin
      w_idx_nxt = '0;
    end else if (w_cnt_wrap) begin
      w_idx_nxt = r_idx + 1'b1;
    end
  end

  // w_zero_from[i]: nibble i and every nibble above it are zero.
  always_comb begin
    w_run       = 1'b1;
    w_zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run && (r_act_data[4*i +: 4] == 4'h0);
      w_zero_from[i] = w_run;
    end
  end

  // Outputs are computed for the post-edge slot position so the registered
  // anode/seg/dp always describe the digit currently being scanned.
  always_comb begin
    w_state_nxt = r_state;
    w_an_raw    = '0;
    w_seg_raw   = '0;
    w_dp_raw    = 1'b0;
    w_nib       = r_act_data[{w_idx_nxt, 2'b00} +: 4];
    w_dark      = !r_act_en[w_idx_nxt] ||
                  (r_act_blz && (w_idx_nxt != '0) && w_zero_from[w_idx_nxt]);
    case (r_state)
      ST_DEAD:  if (!w_cnt_wrap && (r_cnt == C_DEAD_LAST)) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_cnt_wrap) w_state_nxt = ST_DEAD;
      default:  w_state_nxt = ST_DEAD;
    endcase
    if ((w_state_nxt == ST_DRIVE) && !w_dark) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_an_raw[i] = (C_IDX_W'(i) == w_idx_nxt);
      end
      w_seg_raw = ~f_decode(w_nib);
      w_dp_raw  = r_act_dp[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_DEAD;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Active copy only changes on the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shd_data <= '0;
      r_shd_dp   <= '0;
      r_shd_en   <= '0;
      r_shd_blz  <= 1'b0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_act_en   <= '0;
      r_act_blz  <= 1'b0;
    end else begin
      if (load) begin
        r_shd_data <= data;
        r_shd_dp   <= dp_in;
        r_shd_en   <= digit_en;
        r_shd_blz  <= blank_lz;
      end
      if (w_frame) begin
        r_act_data <= r_shd_data;
        r_act_dp   <= r_shd_dp;
        r_act_en   <= r_shd_en;
        r_act_blz  <= r_shd_blz;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode      <= C_AN_OFF;
      seg        <= C_SEG_OFF;
      dp         <= C_DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      anode      <= w_an_raw ^ C_AN_OFF;
      seg        <= w_seg_raw ^ C_SEG_OFF;
      dp         <= w_dp_raw ^ C_DP_OFF;
      frame_tick <= w_frame;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_seg7_scan_driver
// Brief  : Self-checking bench: table vectors, corner sequences, random run
//          against a time-indexed reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] DEC [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] data     = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  digit_en = '0;
  logic        blank_lz = 1'b0;
  logic        load     = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state indexed by edges since reset release.
  int          m_n = 0;
  logic [15:0] m_sd, m_ad;
  logic [3:0]  m_sdp, m_adp, m_sen, m_aen;
  logic        m_sb, m_ab;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .load(load), .seg(seg), .dp(dp), .anode(anode),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpi;
    logic [3:0]  en;
    logic        blz;
    logic [3:0]  lit;   // digits expected to light
    logic [3:0]  dpl;   // digits whose dp is expected lit
    logic [27:0] segs;  // {d3,d2,d1,d0}
  } vec_t;

  vec_t tv [8];

  task automatic model_reset();
    m_n = 0;
    m_sd = '0; m_ad = '0; m_sdp = '0; m_adp = '0;
    m_sen = '0; m_aen = '0; m_sb = 1'b0; m_ab = 1'b0;
  endtask

  task automatic model_update();
    m_n++;
    if (m_n % FRAME == 0) begin
      m_ad = m_sd; m_adp = m_sdp; m_aen = m_sen; m_ab = m_sb;
    end
    if (load) begin
      m_sd = data; m_sdp = dp_in; m_sen = digit_en; m_sb = blank_lz;
    end
  endtask

  task automatic model_expect(output logic [3:0] an, output logic [6:0] sg,
                              output logic d, output logic ft);
    int p, slot, c;
    logic [15:0] hi;
    logic lit;
    p    = m_n % FRAME;
    slot = p / RD;
    c    = p % RD;
    hi   = m_ad >> (4 * slot);
    lit  = (c >= DC) && m_aen[slot] && !(m_ab && slot > 0 && hi == 16'h0);
    an = 4'hF; sg = 7'h7F; d = 1'b1;
    ft = (m_n > 0) && (p == 0);
    if (lit) begin
      an = ~(4'b0001 << slot);
      sg = DEC[hi[3:0]];
      d  = ~m_adp[slot];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic ed, ef;
    @(posedge clk);
    model_update();
    #1;
    model_expect(ea, es, ed, ef);
    chk($sformatf("model n=%0d {an,seg,dp,ft}", m_n),
        {19'd0, anode, seg, dp, frame_tick}, {19'd0, ea, es, ed, ef});
  endtask

  task automatic sync_to(input int target);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((m_n % FRAME) != target && k < 2 * FRAME);
    if ((m_n % FRAME) != target) begin
      n_vec++; n_err++;
      $display("FAIL sync: position %0d never reached", target);
    end
  endtask

  task automatic expect_at(input string name, input int target,
                           input logic [3:0] an, input logic [6:0] sg);
    sync_to(target);
    chk(name, {21'd0, anode, seg}, {21'd0, an, sg});
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dpi,
                        input logic [3:0] en, input logic blz);
    data = d; dp_in = dpi; digit_en = en; blank_lz = blz;
  endtask

  task automatic load_and_sync(input logic [15:0] d, input logic [3:0] dpi,
                               input logic [3:0] en, input logic blz);
    set_in(d, dpi, en, blz);
    load = 1'b1;
    step();
    load = 1'b0;
    sync_to(0);
  endtask

  initial begin
    int got;
    tv[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0, {7'h4F, 7'h12, 7'h06, 7'h4C}};
    tv[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, 4'h3, 4'h0, {7'h7F, 7'h7F, 7'h24, 7'h01}};
    tv[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'h1, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
    tv[3] = '{16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0, {7'h08, 7'h60, 7'h31, 7'h42}};
    tv[4] = '{16'h1234, 4'h4, 4'hB, 1'b0, 4'hB, 4'h0, {7'h4F, 7'h7F, 7'h06, 7'h4C}};
    tv[5] = '{16'h0F00, 4'h1, 4'hF, 1'b1, 4'h7, 4'h1, {7'h7F, 7'h38, 7'h01, 7'h01}};
    tv[6] = '{16'h8E96, 4'hA, 4'hF, 1'b0, 4'hF, 4'hA, {7'h00, 7'h30, 7'h0C, 7'h20}};
    tv[7] = '{16'h7000, 4'h0, 4'h5, 1'b1, 4'h5, 4'h0, {7'h7F, 7'h01, 7'h7F, 7'h01}};

    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset outputs", {19'd0, anode, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk);
    reset_n = 1'b1;

    got = 0;
    for (int k = 1; k <= FRAME + 8; k++) begin
      step();
      if (frame_tick) begin
        got = k;
        break;
      end
    end
    chk("first frame_tick latency", 32'(got), 32'd32);

    // Table vectors: each checked mid-DRIVE of every slot in the following frame.
    for (int i = 0; i < 8; i++) begin
      load_and_sync(tv[i].data, tv[i].dpi, tv[i].en, tv[i].blz);
      for (int k = 0; k < FRAME; k++) begin
        int p, s;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        step();
        p = m_n % FRAME;
        if (p % RD == 5) begin
          s  = p / RD;
          ea = tv[i].lit[s] ? ~(4'b0001 << s) : 4'hF;
          es = tv[i].lit[s] ? tv[i].segs[7*s +: 7] : 7'h7F;
          ed = ~tv[i].dpl[s];
          chk($sformatf("table %0d digit %0d", i, s),
              {20'd0, ea == ea ? anode : 4'h0, seg, dp}, {20'd0, ea, es, ed});
        end
      end
    end

    // Load mid-frame: current frame unchanged, next frame shows new value.
    load_and_sync(16'h1234, 4'h0, 4'hF, 1'b0);
    sync_to(10);
    data = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    expect_at("midload d1 old", 13, 4'hD, 7'h06);
    expect_at("midload d2 old", 21, 4'hB, 7'h12);
    expect_at("midload d3 old", 29, 4'h7, 7'h4F);
    expect_at("midload d0 new", 5,  4'hE, 7'h42);
    expect_at("midload d1 new", 13, 4'hD, 7'h31);

    // Load on the boundary edge: transfer takes the pre-edge shadow.
    sync_to(12);
    data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    sync_to(31);
    data = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    expect_at("boundary load old", 5,  4'hE, 7'h4C);
    expect_at("boundary load new", 5,  4'hE, 7'h00);
    expect_at("boundary load d1",  13, 4'hD, 7'h0F);

    // Asynchronous reset mid-DRIVE of digit 2.
    sync_to(20);
    reset_n = 1'b0;
    #1;
    chk("async reset outputs", {19'd0, anode, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    got = 0;
    for (int k = 1; k <= FRAME + 8; k++) begin
      step();
      if (frame_tick) begin
        got = k;
        break;
      end
    end
    chk("frame_tick after reset", 32'(got), 32'd32);
    expect_at("shadow cleared", 5, 4'hF, 7'h7F);

    // Random run against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int j = 0; j < 4; j++) begin
        data[4*j +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
      end
      dp_in    = 4'($urandom_range(15, 0));
      digit_en = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'hF;
      blank_lz = 1'($urandom_range(1, 0));
      load     = ($urandom_range(15, 0) == 0);
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
